// File: rtl/priority_arbiter_if.sv
// -----------------------------------------------------------------------------
// priority_arbiter_if
// Groups the request/grant signals of the 4-requester priority arbiter.
//   req       : 4-bit request vector, driven by the requesters
//   gnt       : 4-bit registered one-hot grant
//   gnt_valid : 1 when gnt is non-zero
//   gnt_id    : index of the current owner (0 when no owner)
//   preempt   : one-cycle pulse when ownership ends by hold-limit expiry
// Modports:
//   master : requester side (drives req, observes grant signals)
//   slave  : arbiter side (observes req, drives grant signals)
// -----------------------------------------------------------------------------
interface priority_arbiter_if;
    logic [3:0] req;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_valid,
        input  gnt_id,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_valid,
        output gnt_id,
        output preempt
    );
endinterface

// File: rtl/priority_arbiter.sv
// -----------------------------------------------------------------------------
// priority_arbiter
// Four-requester arbiter with a bounded ownership time. An owner keeps the
// grant while it requests, for at most MAXHOLD consecutive cycles; every end
// of ownership is followed by exactly one idle (RELEASE) cycle before the next
// grant is issued. Non-owners never preempt an active owner.
//
// Parameters:
//   MAXHOLD : maximum consecutive grant cycles per ownership (2..255)
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : priority_arbiter_if.slave (req in; gnt, gnt_valid, gnt_id,
//           preempt out, all registered)
// Configuration macro:
//   ROUND_ROBIN_ARB_EN : when defined, the winner is the first set request
//                        searching downward (with wrap) from a rotating
//                        pointer; otherwise the highest-index request wins.
// -----------------------------------------------------------------------------
module priority_arbiter #(
    parameter int MAXHOLD = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    priority_arbiter_if.slave     bus
);

    localparam logic [7:0] MAXHOLD_C = 8'(MAXHOLD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [3:0] gnt_r;
    logic [3:0] gnt_nxt_s;
    logic       valid_r;
    logic       valid_nxt_s;
    logic [1:0] id_r;
    logic [1:0] id_nxt_s;
    logic       preempt_r;
    logic       preempt_nxt_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nxt_s;
    logic [1:0] winner_s;

`ifdef ROUND_ROBIN_ARB_EN
    logic [1:0] ptr_r;
    logic [1:0] ptr_nxt_s;

    // First set request scanning ptr, ptr-1, ... with wrap modulo 4.
    function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = 2'd0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx   = ptr - 2'(k);
            win   = (!found && r[idx]) ? idx : win;
            found = found | r[idx];
        end
        return win;
    endfunction

    // Winner under rotating priority.
    always_comb begin
        winner_s = pick_winner(bus.req, ptr_r);
    end
`else
    // Highest-index set request wins.
    function automatic logic [1:0] pick_winner(input logic [3:0] r);
        return r[3] ? 2'd3 :
               r[2] ? 2'd2 :
               r[1] ? 2'd1 : 2'd0;
    endfunction

    // Winner under fixed priority.
    always_comb begin
        winner_s = pick_winner(bus.req);
    end
`endif

    // Next-state and next-output logic of the arbitration FSM.
    always_comb begin
        state_nxt_s   = state_r;
        gnt_nxt_s     = 4'b0000;
        valid_nxt_s   = 1'b0;
        id_nxt_s      = 2'd0;
        preempt_nxt_s = 1'b0;
        cnt_nxt_s     = cnt_r;
`ifdef ROUND_ROBIN_ARB_EN
        ptr_nxt_s     = ptr_r;
`endif
        case (state_r)
            // RELEASE evaluates requests exactly like IDLE at its exit edge.
            IDLE, RELEASE: begin
                if (bus.req != 4'b0000) begin
                    state_nxt_s = GRANT;
                    gnt_nxt_s   = 4'b0001 << winner_s;
                    valid_nxt_s = 1'b1;
                    id_nxt_s    = winner_s;
                    cnt_nxt_s   = 8'd1;
`ifdef ROUND_ROBIN_ARB_EN
                    ptr_nxt_s   = winner_s - 2'd1;
`endif
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = 8'd0;
                end
            end
            GRANT: begin
                // A drop takes precedence over expiry, so no preempt then.
                if (!bus.req[id_r]) begin
                    state_nxt_s = RELEASE;
                    cnt_nxt_s   = 8'd0;
                end else if (cnt_r == MAXHOLD_C) begin
                    state_nxt_s   = RELEASE;
                    preempt_nxt_s = 1'b1;
                    cnt_nxt_s     = 8'd0;
                end else begin
                    state_nxt_s = GRANT;
                    gnt_nxt_s   = gnt_r;
                    valid_nxt_s = 1'b1;
                    id_nxt_s    = id_r;
                    cnt_nxt_s   = cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 8'd0;
            end
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            gnt_r     <= 4'b0000;
            valid_r   <= 1'b0;
            id_r      <= 2'd0;
            preempt_r <= 1'b0;
            cnt_r     <= 8'd0;
`ifdef ROUND_ROBIN_ARB_EN
            ptr_r     <= 2'd3;
`endif
        end else begin
            state_r   <= state_nxt_s;
            gnt_r     <= gnt_nxt_s;
            valid_r   <= valid_nxt_s;
            id_r      <= id_nxt_s;
            preempt_r <= preempt_nxt_s;
            cnt_r     <= cnt_nxt_s;
`ifdef ROUND_ROBIN_ARB_EN
            ptr_r     <= ptr_nxt_s;
`endif
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.gnt_valid = valid_r;
    assign bus.gnt_id    = id_r;
    assign bus.preempt   = preempt_r;

endmodule

// File: tb/tb_priority_arbiter.sv
// -----------------------------------------------------------------------------
// tb_priority_arbiter
// Directed and random stimulus for priority_arbiter. Two instances are used:
// one with MAXHOLD=8 and one with MAXHOLD=4. Expected outputs are queued when
// the stimulus is applied and popped one cycle later when the DUT responds.
// -----------------------------------------------------------------------------
module tb_priority_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [4:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    priority_arbiter_if if8();
    priority_arbiter_if if4();

    priority_arbiter #(.MAXHOLD(8)) u8 (.clk(clk), .reset(reset), .bus(if8));
    priority_arbiter #(.MAXHOLD(4)) u4 (.clk(clk), .reset(reset), .bus(if4));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] idx_of(input logic [3:0] g);
        return g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    endfunction

    // Apply req (and reset) to one DUT, queue the expected response, compare it.
    task automatic step(input int which, input logic rst, input logic [3:0] r,
                        input logic [3:0] eg, input logic ep, input string tag);
        logic [4:0] e;
        string      t;
        logic [3:0] g;
        logic       v;
        logic [1:0] id;
        logic       p;
        reset = rst;
        if (which == 8) if8.req = r;
        else            if4.req = r;
        exp_q.push_back({ep, eg});
        tag_q.push_back(tag);
        @(negedge clk);
        if (which == 8) begin
            g = if8.gnt; v = if8.gnt_valid; id = if8.gnt_id; p = if8.preempt;
        end else begin
            g = if4.gnt; v = if4.gnt_valid; id = if4.gnt_id; p = if4.preempt;
        end
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk({t, "_gnt"},     8'(g),  8'(e[3:0]));
        chk({t, "_valid"},   8'(v),  8'(|e[3:0]));
        chk({t, "_id"},      8'(id), 8'(idx_of(e[3:0])));
        chk({t, "_preempt"}, 8'(p),  8'(e[4]));
    endtask

    initial begin
        logic [3:0] rq;
        logic [3:0] prev_gnt;
        logic [3:0] g;
        logic [3:0] second;
        int         run;

        reset   = 1'b1;
        if8.req = 4'b0000;
        if4.req = 4'b0000;
        repeat (2) @(negedge clk);
        chk("rst_gnt",     8'(if8.gnt),       8'h00);
        chk("rst_valid",   8'(if8.gnt_valid), 8'h00);
        chk("rst_id",      8'(if8.gnt_id),    8'h00);
        chk("rst_preempt", 8'(if8.preempt),   8'h00);
        chk("rst_gnt4",    8'(if4.gnt),       8'h00);

        // Idle with no requests.
        for (int i = 0; i < 5; i++) step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "idle");

        // Fixed-priority hold on MAXHOLD=4: owner 3 regranted every 5 cycles.
`ifdef ROUND_ROBIN_ARB_EN
        second = 4'b0001;
`else
        second = 4'b1000;
`endif
        for (int i = 0; i < 4; i++) step(4, 1'b0, 4'b1001, 4'b1000, 1'b0, "mh4_a");
        step(4, 1'b0, 4'b1001, 4'b0000, 1'b1, "mh4_pre1");
        for (int i = 0; i < 4; i++) step(4, 1'b0, 4'b1001, second, 1'b0, "mh4_b");
        step(4, 1'b0, 4'b1001, 4'b0000, 1'b1, "mh4_pre2");
        step(4, 1'b0, 4'b1001, 4'b1000, 1'b0, "mh4_c");
        step(4, 1'b0, 4'b0000, 4'b0000, 1'b0, "mh4_drop");
        step(4, 1'b0, 4'b0000, 4'b0000, 1'b0, "mh4_idle");

        // Owner 3 drops, owner 2 takes over after one gap cycle.
        for (int i = 0; i < 4; i++) step(8, 1'b0, 4'b1100, 4'b1000, 1'b0, "hand_own3");
        step(8, 1'b0, 4'b0100, 4'b0000, 1'b0, "hand_gap");
        step(8, 1'b0, 4'b0100, 4'b0100, 1'b0, "hand_own2");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "hand_rel");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "hand_idle");

        // MAXHOLD=8 expiry with preempt, then regrant.
        for (int i = 0; i < 8; i++) step(8, 1'b0, 4'b0001, 4'b0001, 1'b0, "exp_hold");
        step(8, 1'b0, 4'b0001, 4'b0000, 1'b1, "exp_pre");
        step(8, 1'b0, 4'b0001, 4'b0001, 1'b0, "exp_regrant");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "exp_rel");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "exp_idle");

        // Drop coinciding with expiry is a drop: no preempt.
        for (int i = 0; i < 8; i++) step(8, 1'b0, 4'b0001, 4'b0001, 1'b0, "dx_hold");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "dx_drop");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "dx_idle");

        // Higher-priority newcomer does not preempt the owner.
        step(8, 1'b0, 4'b0001, 4'b0001, 1'b0, "np_own0");
        step(8, 1'b0, 4'b1001, 4'b0001, 1'b0, "np_keep");
        step(8, 1'b0, 4'b1000, 4'b0000, 1'b0, "np_gap");
        step(8, 1'b0, 4'b1000, 4'b1000, 1'b0, "np_own3");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "np_rel");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "np_idle");

        // Reset mid-grant drops immediately; regrant right after deassert.
        step(8, 1'b0, 4'b0100, 4'b0100, 1'b0, "rm_own2");
        step(8, 1'b0, 4'b0100, 4'b0100, 1'b0, "rm_hold");
        step(8, 1'b1, 4'b0100, 4'b0000, 1'b0, "rm_reset");
        step(8, 1'b0, 4'b0100, 4'b0100, 1'b0, "rm_regrant");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "rm_rel");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "rm_idle");

        // Winner selection among simultaneous requests.
        step(8, 1'b0, 4'b0110, 4'b0100, 1'b0, "pri_0110");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "pri_rel1");
        step(8, 1'b0, 4'b0011, 4'b0010, 1'b0, "pri_0011");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "pri_rel2");
        step(8, 1'b0, 4'b0000, 4'b0000, 1'b0, "pri_idle");

        // Random requests with invariant checks on the MAXHOLD=8 instance.
        rq       = 4'b0000;
        prev_gnt = 4'b0000;
        run      = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) rq[b] = ~rq[b];
            end
            if8.req = rq;
            @(negedge clk);
            g = if8.gnt;
            chk("rnd_onehot", 8'($onehot0(g)), 8'h01);
            chk("rnd_valid",  8'(if8.gnt_valid), 8'(|g));
            if (g != 4'b0000) begin
                if (g == prev_gnt) begin
                    run++;
                end else begin
                    run = 1;
                    chk("rnd_to_requester", 8'(|(g & rq)), 8'h01);
                    chk("rnd_gap_before",   8'(prev_gnt == 4'b0000), 8'h01);
                end
                chk("rnd_hold_le_max", 8'(run <= 8), 8'h01);
            end else begin
                run = 0;
            end
            prev_gnt = g;
        end
        if8.req = 4'b0000;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter: MAXHOLD, default 8, maximum consecutive grant cycles per ownership; legal range 2..255.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req  input  4  request vector; requester i holds req[i]=1 while it wants the resource.
REQ-005 gnt  output  4  registered one-hot grant; all zero when no owner.
REQ-006 gnt_valid  output  1  registered; 1 exactly when gnt is non-zero.
REQ-007 gnt_id  output  2  registered index of current owner; 0 when gnt_valid=0.
REQ-008 preempt  output  1  registered one-cycle pulse in the cycle ownership ends by MAXHOLD expiry.

Function
REQ-009 The FSM SHALL have three states: IDLE, GRANT, RELEASE; all outputs registered, no combinational path from req to any output.
REQ-010 IDLE: if req!=0 at edge N, SHALL enter GRANT with gnt set to the winner at edge N (visible cycle N+1); else stay IDLE.
REQ-011 Winner selection (fixed priority, default): highest-index set bit of req wins (req[3] highest, req[0] lowest).
REQ-012 GRANT: hold counter SHALL load 1 on grant entry and increment each cycle the owner stays.
REQ-013 GRANT: if req[gnt_id]=0 at an edge, SHALL go to RELEASE with gnt=0 at that edge; preempt stays 0.
REQ-014 GRANT: if req[gnt_id]=1 and counter=MAXHOLD at an edge, SHALL go to RELEASE with gnt=0 and preempt=1 for that one cycle.
REQ-015 Owner drop and MAXHOLD expiry at the same edge SHALL be treated as a drop (preempt=0).
REQ-016 Requests from non-owners during GRANT SHALL NOT change gnt; no preemption by higher priority.
REQ-017 RELEASE SHALL last exactly one cycle with gnt=0; at its exit edge the arbiter SHALL evaluate req as in IDLE and enter GRANT (with winner) or IDLE.
REQ-018 Consequently handover between owners SHALL leave exactly one gnt=0 cycle; maximum ownership is MAXHOLD cycles.
REQ-019 gnt SHALL never have more than one bit set; gnt_valid SHALL equal |gnt every cycle.

Reset
REQ-020 reset=1 at an edge SHALL force IDLE, gnt=0, gnt_valid=0, gnt_id=0, preempt=0, counter=0, round-robin pointer=3, regardless of state.
REQ-021 Reset asserted mid-GRANT SHALL drop the grant at that edge with no RELEASE cycle and no preempt pulse.
REQ-022 First grant is possible at the first edge after reset deasserts.

Configuration
REQ-023 Macro ROUND_ROBIN_ARB_EN: when defined, winner SHALL be the first set req bit searching downward from pointer ptr with wrap (ptr, ptr-1, ..., 0, 3, ...); after each grant to i, ptr SHALL become (i-1) mod 4.
REQ-024 When ROUND_ROBIN_ARB_EN is undefined, fixed priority of REQ-011 SHALL apply and no pointer register SHALL exist; all other behaviour identical.

Verification
REQ-025 Reset, then req=4'b0000 for 5 cycles -> gnt=0000, gnt_valid=0, FSM IDLE throughout.
REQ-026 req=4'b1100 asserted at cycle 0 from IDLE -> gnt=1000, gnt_id=3 from cycle 1; req[3] dropped at cycle 4 -> gnt=0000 cycle 5, gnt=0100 cycle 6.
REQ-027 MAXHOLD=8, req=4'b0001 held -> gnt=0001 cycles 1-8, gnt=0000 with preempt=1 cycle 9, gnt=0001 again cycle 10.
REQ-028 Fixed priority, req=4'b1001 held, MAXHOLD=4 -> requester 3 regranted every 5 cycles, requester 0 never granted; with ROUND_ROBIN_ARB_EN -> grants alternate 1000, 0001, 1000.
REQ-029 Owner 2 granted (req=4'b0100), reset pulsed one cycle mid-grant -> gnt=0000, preempt=0 the cycle after reset edge; regrant 0100 the cycle after reset deasserts.
REQ-030 Random req over 10000 cycles -> assert gnt one-hot or zero, gnt_valid=|gnt, ownership never exceeds MAXHOLD, gnt only to a requester whose req was 1 at the grant edge.
